multiplexor_4a1_condicional: RTL and testbench

//   Registered 4-to-1 word multiplexer. SEL picks one of four WIDTH-bit

---
 rtl/multiplexor_4a1_condicional.sv | 52 +++++
 tb/tb_multiplexor_4a1_condicional.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/multiplexor_4a1_condicional.sv
// ============================================================================
// Module   : multiplexor_4a1_condicional
// Purpose  : Registered 4-to-1 word multiplexer with a combinational tap.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multiplexor_4a1_condicional #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  input  logic [WIDTH-1:0] L0,
  input  logic [WIDTH-1:0] L1,
  input  logic [WIDTH-1:0] L2,
  input  logic [WIDTH-1:0] L3,
  input  logic [1:0]       SEL,
  output logic [WIDTH-1:0] R_COMB,
  output logic [WIDTH-1:0] R,
  output logic [1:0]       SEL_Q,
  output logic             R_VALID
);

  // The default arm keeps synthesis deterministic for SEL values that cannot legally occur.
  always_comb begin
    R_COMB = L0;
    case (SEL)
      2'b00:   R_COMB = L0;
      2'b01:   R_COMB = L1;
      2'b10:   R_COMB = L2;
      2'b11:   R_COMB = L3;
      default: R_COMB = L0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      R       <= RESET_VAL;
      SEL_Q   <= 2'b00;
      R_VALID <= 1'b0;
    end else if (EN) begin
      R       <= R_COMB;
      SEL_Q   <= SEL;
      R_VALID <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multiplexor_4a1_condicional.sv
// Testbench for multiplexor_4a1_condicional: directed scenarios plus random
// traffic compared against an array-indexed reference model.
`default_nettype none

module tb_multiplexor_4a1_condicional;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             EN;
  logic [WIDTH-1:0] L0, L1, L2, L3;
  logic [1:0]       SEL;
  logic [WIDTH-1:0] R_COMB, R;
  logic [1:0]       SEL_Q;
  logic             R_VALID;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [WIDTH-1:0] m_r;
  logic [1:0]       m_selq;
  logic             m_valid;

  multiplexor_4a1_condicional #(.WIDTH(WIDTH), .RESET_VAL(4'b0000)) dut (
    .clk(clk), .rst(rst), .EN(EN),
    .L0(L0), .L1(L1), .L2(L2), .L3(L3), .SEL(SEL),
    .R_COMB(R_COMB), .R(R), .SEL_Q(SEL_Q), .R_VALID(R_VALID)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [WIDTH-1:0] pick(input logic [1:0] s);
    logic [WIDTH-1:0] lanes [4];
    lanes[0] = L0; lanes[1] = L1; lanes[2] = L2; lanes[3] = L3;
    return lanes[s];
  endfunction

  // Advance one edge while updating the model from the values presented before it.
  task automatic step();
    logic [WIDTH-1:0] sel_val;
    sel_val = pick(SEL);
    if (rst) begin
      m_r = '0; m_selq = 2'b00; m_valid = 1'b0;
    end else if (EN) begin
      m_r = sel_val; m_selq = SEL; m_valid = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".R"},       32'(R),       32'(m_r));
    check({tag, ".SEL_Q"},   32'(SEL_Q),   32'(m_selq));
    check({tag, ".R_VALID"}, 32'(R_VALID), 32'(m_valid));
  endtask

  task automatic set_lanes(input logic [WIDTH-1:0] a, b, c, d);
    L0 = a; L1 = b; L2 = c; L3 = d;
  endtask

  initial begin
    m_r = '0; m_selq = '0; m_valid = 1'b0;
    rst = 1'b1; EN = 1'b0; SEL = 2'b00;
    set_lanes(4'h0, 4'h0, 4'h0, 4'h0);
    #2;

    // 1: reset for two clocks, then idle
    step(); step();
    rst = 1'b0;
    step();
    check("reset.R", 32'(R), 32'h0);
    check("reset.SEL_Q", 32'(SEL_Q), 32'h0);
    check("reset.R_VALID", 32'(R_VALID), 32'h0);

    // 2: first capture, combinational tap immediate
    EN = 1'b1; set_lanes(4'b0001, 4'b0000, 4'b0000, 4'b0000); SEL = 2'b00;
    #1;
    check("t2.R_COMB", 32'(R_COMB), 32'b0001);
    check("t2.R_before", 32'(R), 32'h0);
    step();
    check("t2.R", 32'(R), 32'b0001);
    check("t2.R_VALID", 32'(R_VALID), 32'h1);

    // 3: walking one through each lane
    set_lanes(4'b0000, 4'b0001, 4'b0000, 4'b0000); SEL = 2'b01; step();
    check("t3a.R", 32'(R), 32'b0001); check("t3a.SEL_Q", 32'(SEL_Q), 32'b01);
    set_lanes(4'b0000, 4'b0000, 4'b0001, 4'b0000); SEL = 2'b10; step();
    check("t3b.R", 32'(R), 32'b0001); check("t3b.SEL_Q", 32'(SEL_Q), 32'b10);
    set_lanes(4'b0000, 4'b0000, 4'b0000, 4'b0001); SEL = 2'b11; step();
    check("t3c.R", 32'(R), 32'b0001); check("t3c.SEL_Q", 32'(SEL_Q), 32'b11);

    // 4: distinct lane patterns, SEL sweep
    set_lanes(4'b1010, 4'b0101, 4'b1100, 4'b0011);
    for (int s = 0; s < 4; s++) begin
      logic [3:0] exp_tab [4];
      exp_tab[0] = 4'b1010; exp_tab[1] = 4'b0101; exp_tab[2] = 4'b1100; exp_tab[3] = 4'b0011;
      SEL = 2'(s);
      #1;
      check("t4.R_COMB", 32'(R_COMB), 32'(exp_tab[s]));
      step();
      check("t4.R", 32'(R), 32'(exp_tab[s]));
      check("t4.SEL_Q", 32'(SEL_Q), s);
    end

    // 5: hold with mid-cycle changes
    EN = 1'b0;
    #2; SEL = 2'b00; set_lanes(4'b1111, 4'b1110, 4'b1101, 4'b1011);
    #1; check("t5.R_COMB_a", 32'(R_COMB), 32'b1111);
    check("t5.R_mid", 32'(R), 32'b0011);
    #1; SEL = 2'b10;
    #1; check("t5.R_COMB_b", 32'(R_COMB), 32'b1101);
    step();
    check("t5.R_hold", 32'(R), 32'b0011);
    check("t5.SEL_Q_hold", 32'(SEL_Q), 32'b11);
    check("t5.R_VALID_hold", 32'(R_VALID), 32'h1);

    // 6: reset beats enable
    EN = 1'b1; SEL = 2'b11; set_lanes(4'h0, 4'h0, 4'h0, 4'b0011); step();
    check("t6.cap", 32'(R), 32'b0011);
    rst = 1'b1; SEL = 2'b01; set_lanes(4'h0, 4'b1001, 4'h0, 4'h0);
    #1; check("t6.R_COMB_in_rst", 32'(R_COMB), 32'b1001);
    step();
    check("t6.R", 32'(R), 32'h0);
    check("t6.R_VALID", 32'(R_VALID), 32'h0);
    check("t6.SEL_Q", 32'(SEL_Q), 32'h0);
    rst = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 19) == 0);
      EN  = $urandom_range(0, 1) == 1;
      SEL = 2'($urandom);
      set_lanes(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      #1;
      check("rand.R_COMB", 32'(R_COMB), 32'(pick(SEL)));
      step();
      check_regs("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

`default_nettype wire
